// File: rtl/decode_stage.sv
// RV32I decode stage: registered decode fields behind a valid/ready handshake,
// with a pending-write scoreboard that stalls read-after-write hazards.
module decode_stage #(
    parameter int XLEN        = 32,
    parameter int NREGS       = 32,
    parameter int STALL_CNT_W = 16,
    localparam int REG_AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [31:0]            out_inst,
    output logic [REG_AW-1:0]      out_rs1,
    output logic [REG_AW-1:0]      out_rs2,
    output logic [REG_AW-1:0]      out_rd,
    output logic                   out_reg_we,
    output logic [1:0]             out_wb_sel,
    output logic                   out_illegal,
    input  logic                   wb_valid,
    input  logic [REG_AW-1:0]      wb_rd,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_MISC = 7'b0001111,
                           OP_IMM  = 7'b0010011, OP_AUIPC = 7'b0010111,
                           OP_STORE = 7'b0100011, OP_OP = 7'b0110011,
                           OP_LUI  = 7'b0110111, OP_BRANCH = 7'b1100011,
                           OP_JALR = 7'b1100111, OP_JAL = 7'b1101111,
                           OP_SYS  = 7'b1110011;

    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_SYS = 2'd3;

    logic [NREGS-1:0]  sb, sb_nxt;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              we, illegal, use_rs1, use_rs2, hazard, issue, room;
    logic [1:0]        wb_sel;

    assign rs1 = REG_AW'(in_inst[19:15]);
    assign rs2 = REG_AW'(in_inst[24:20]);
    assign rd  = REG_AW'(in_inst[11:7]);

    always_comb begin
        we      = 1'b0;
        wb_sel  = WB_ALU;
        illegal = 1'b0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        unique case (in_inst[6:0])
            OP_OP:               begin we = 1'b1; use_rs2 = 1'b1; end
            OP_IMM:              we = 1'b1;
            OP_LUI, OP_AUIPC:    begin we = 1'b1; use_rs1 = 1'b0; end
            OP_LOAD:             begin we = 1'b1; wb_sel = WB_MEM; end
            OP_JAL:              begin we = 1'b1; wb_sel = WB_PC4; use_rs1 = 1'b0; end
            OP_JALR:             begin we = 1'b1; wb_sel = WB_PC4; end
            OP_SYS:              begin we = 1'b1; wb_sel = WB_SYS; end
            OP_STORE, OP_BRANCH: use_rs2 = 1'b1;
            OP_MISC:             use_rs1 = 1'b0;
            default:             begin illegal = 1'b1; use_rs1 = 1'b0; end
        endcase
        // Quadrant bits are part of every legal opcode above; kept explicit for clarity.
        if (in_inst[1:0] != 2'b11) begin
            illegal = 1'b1;
            we      = 1'b0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
        if (rd == '0) we = 1'b0;
    end

    // Registered scoreboard only; a same-cycle writeback does not unblock.
    assign hazard   = (use_rs1 && sb[rs1]) || (use_rs2 && sb[rs2]);
    assign room     = !out_valid || out_ready;
    assign in_ready = rst_n && !flush && !hazard && room;
    assign issue    = in_valid && in_ready;

    always_comb begin
        sb_nxt = sb;
        if (wb_valid) sb_nxt[wb_rd] = 1'b0;
        if (issue && we) sb_nxt[rd] = 1'b1;   // set after clear: set wins
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_inst    <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_reg_we  <= 1'b0;
            out_wb_sel  <= '0;
            out_illegal <= 1'b0;
            sb          <= '0;
            stall_cnt   <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
                sb        <= '0;
            end else begin
                sb <= sb_nxt;
                if (issue) begin
                    out_valid   <= 1'b1;
                    out_pc      <= in_pc;
                    out_inst    <= in_inst;
                    out_rs1     <= rs1;
                    out_rs2     <= rs2;
                    out_rd      <= rd;
                    out_reg_we  <= we;
                    out_wb_sel  <= wb_sel;
                    out_illegal <= illegal;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (in_valid && hazard && room && !(&stall_cnt))
                    stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, scoreboard stalls, hold, illegal, flush.
module tb_decode_stage;
    logic        clk = 1'b0, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_inst;
    logic [4:0]  out_rs1, out_rs2, out_rd, wb_rd;
    logic        out_reg_we, out_illegal, wb_valid;
    logic [1:0]  out_wb_sel;
    logic [15:0] stall_cnt;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_reg_we(out_reg_we), .out_wb_sel(out_wb_sel),
        .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; in_inst = '0; in_pc = '0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_sb", dut.sb, 32'd0);
        rst_n = 1'b1; #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // addi x5,x0,1
        present(32'h0010_0293, 32'h100);
        tick();
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_rd", 32'(out_rd), 32'd5);
        chk("addi_we", 32'(out_reg_we), 32'd1);
        chk("addi_wb", 32'(out_wb_sel), 32'd0);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_sb", dut.sb, 32'h0000_0020);

        // add x6,x5,x5 stalls on x5
        present(32'h0052_8333, 32'h104);
        chk("raw_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("raw_stall1", 32'(stall_cnt), 32'd1);
        chk("raw_drain", 32'(out_valid), 32'd0);
        tick();
        chk("raw_stall2", 32'(stall_cnt), 32'd2);
        chk("raw_still_blocked", 32'(in_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5; #1;
        chk("raw_no_bypass", 32'(in_ready), 32'd0);
        tick();
        wb_valid = 1'b0; #1;
        chk("raw_stall3", 32'(stall_cnt), 32'd3);
        chk("raw_sb_cleared", dut.sb, 32'd0);
        chk("raw_unblocked", 32'(in_ready), 32'd1);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_rd", 32'(out_rd), 32'd6);
        chk("add_rs1", 32'(out_rs1), 32'd5);
        chk("add_rs2", 32'(out_rs2), 32'd5);
        chk("add_sb", dut.sb, 32'h0000_0040);

        // lw x7,0(x1) then hold with out_ready=0
        present(32'h0000_a383, 32'h108);
        tick();
        out_ready = 1'b0;
        present(32'h0000_0013, 32'h10c);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        chk("hold_inst", out_inst, 32'h0000_a383);
        chk("hold_pc", out_pc, 32'h108);
        chk("hold_wb_mem", 32'(out_wb_sel), 32'd1);
        chk("hold_rd", 32'(out_rd), 32'd7);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_no_stall", 32'(stall_cnt), 32'd3);
        chk("hold_sb", dut.sb, 32'h0000_00c0);

        // unknown opcode, then nop (rd=0)
        out_ready = 1'b1;
        present(32'h0000_007f, 32'h10c);
        tick();
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_we", 32'(out_reg_we), 32'd0);
        chk("ill_sb", dut.sb, 32'h0000_00c0);
        present(32'h0000_0013, 32'h110);
        tick();
        chk("nop_we", 32'(out_reg_we), 32'd0);
        chk("nop_illegal", 32'(out_illegal), 32'd0);
        chk("nop_sb", dut.sb, 32'h0000_00c0);

        // flush with out_valid=1 and sb[5]=1
        present(32'h0010_0293, 32'h114);
        tick();
        chk("pre_flush_sb", dut.sb, 32'h0000_00e0);
        flush = 1'b1;
        present(32'h0000_0013, 32'h118);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_sb", dut.sb, 32'd0);

        // issue and writeback to the same rd: set wins
        present(32'h0010_0293, 32'h200);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd5;
        present(32'h0010_0293, 32'h204);
        tick();
        wb_valid = 1'b0;
        chk("set_wins_sb", dut.sb, 32'h0000_0020);
        chk("set_wins_pc", out_pc, 32'h204);

        // lui with rs1 field == 5 does not read rs1
        present(32'h0002_d0b7, 32'h208);
        chk("lui_no_rs1", 32'(in_ready), 32'd1);
        tick();
        chk("lui_rd", 32'(out_rd), 32'd1);
        chk("lui_sb", dut.sb, 32'h0000_0022);
        present(32'h0000_00ef, 32'h20c);    // jal x1
        tick();
        chk("jal_wb", 32'(out_wb_sel), 32'd2);
        chk("jal_we", 32'(out_reg_we), 32'd1);
        present(32'h0000_0073, 32'h210);    // ecall, rd=0
        tick();
        chk("sys_wb", 32'(out_wb_sel), 32'd3);
        chk("sys_we", 32'(out_reg_we), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("final_drain", 32'(out_valid), 32'd0);
        chk("final_stall", 32'(stall_cnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
